column_readout_ctrl: RTL and testbench

- Column-periphery stage directly downstream of the pixel front-end chain.
- Sequences one frame: opens both counter shutters for a programmed window, closes them, then clocks the daisy-chained LFSR counters out through SerOutA/SerOutB.
- Deserializes both chains in lockstep into per-pixel count words.
- Delivers the words over a valid/ready stream, with chain clock gating for backpressure.

---
 rtl/column_readout_ctrl_pkg.sv | 27 ++
 rtl/column_readout_ctrl_ser2par.sv | 27 ++
 rtl/column_readout_ctrl.sv | 173 +++++++++++++++++
 tb/tb_column_readout_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/column_readout_ctrl_pkg.sv
// Shared types and defaults for the column readout controller (package readout_pkg).
package readout_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACQ    = 3'd1,
        SETTLE = 3'd2,
        SHIFT  = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    localparam int SETTLE_CYC = 2;

    localparam int N_PIX_DEF  = 16;
    localparam int CNT_W_DEF  = 8;
    localparam int ACQ_W_DEF  = 16;
    localparam int BIT_W_DEF  = $clog2(CNT_W_DEF);
    localparam int ADDR_W_DEF = $clog2(N_PIX_DEF);

    // LFSR value a pixel holds after its own reset, i.e. zero hits.
    localparam logic [CNT_W_DEF-1:0] SEED_DEF = '1;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/column_readout_ctrl_ser2par.sv
// MSB-first serial-to-parallel register; o_word already includes the bit being captured.
module ser2par #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_bit,
    input  logic             i_last,
    output logic [CNT_W-1:0] o_word,
    output logic             o_done
);

    logic [CNT_W-2:0] r_sr;

    assign o_word = {r_sr, i_bit};
    assign o_done = i_en && i_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr <= '0;
        end else if (i_en) begin
            r_sr <= o_word[CNT_W-2:0];
        end
    end

endmodule

// File: rtl/column_readout_ctrl.sv
// Frame sequencer: shutter window, settle, chain readout into a one-entry stream buffer.
// Optional zero suppression of all-SEED pixels: define ZERO_SUPPRESS_EN.
module column_readout_ctrl
    import readout_pkg::*;
#(
    parameter int               N_PIX = N_PIX_DEF,
    parameter int               CNT_W = CNT_W_DEF,
    parameter int               ACQ_W = ACQ_W_DEF,
    parameter logic [CNT_W-1:0] SEED  = {CNT_W{1'b1}}
) (
    input  logic                     clk_read,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ACQ_W-1:0]         acq_len,
    output logic                     shutterA,
    output logic                     shutterB,
    output logic                     chain_clk_en,
    output logic                     SerInA,
    output logic                     SerInB,
    input  logic                     SerOutA,
    input  logic                     SerOutB,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [idx_w(N_PIX)-1:0]  out_addr,
    output logic [CNT_W-1:0]         out_cnt_a,
    output logic [CNT_W-1:0]         out_cnt_b,
    output logic                     busy,
    output logic                     frame_done,
    output state_t                   o_dbg_state
);

    localparam int ADDR_W = idx_w(N_PIX);
    localparam int BIT_W  = idx_w(CNT_W);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(CNT_W - 1);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(N_PIX - 1);

`ifdef ZERO_SUPPRESS_EN
    localparam bit ZS_ON = 1'b1;
`else
    localparam bit ZS_ON = 1'b0;
`endif

    state_t              r_state, w_next;
    logic [ACQ_W-1:0]    r_cnt;
    logic [BIT_W-1:0]    r_bit;
    logic [ADDR_W-1:0]   r_pix;
    logic                r_valid, r_frame_done;
    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_cnt_a, r_cnt_b;
    logic [CNT_W-1:0]    w_word_a, w_word_b;
    logic                w_last_bit, w_is_seed, w_keep, w_stall, w_en_shift;
    logic                w_start_ok, w_done_a, w_done_b, w_word_done, w_drain_ok;

    // Stream handshake: a word moves when out_valid & out_ready at a clk_read edge;
    // out_valid never drops and data never changes until that happens.
    assign w_last_bit  = (r_bit == LAST_BIT);
    assign w_is_seed   = (w_word_a == SEED) && (w_word_b == SEED);
    assign w_keep      = !(ZS_ON && w_is_seed);
    assign w_stall     = w_last_bit && w_keep && r_valid && !out_ready;
    assign w_en_shift  = (r_state == SHIFT) && !w_stall;
    assign w_start_ok  = (r_state == IDLE) && start && !r_frame_done;
    assign w_word_done = w_done_a && w_done_b;
    assign w_drain_ok  = !r_valid || out_ready;

    ser2par #(.CNT_W(CNT_W)) u_ser_a (
        .i_clk   (clk_read),
        .i_rst_n (reset),
        .i_en    (w_en_shift),
        .i_bit   (SerOutA),
        .i_last  (w_last_bit),
        .o_word  (w_word_a),
        .o_done  (w_done_a)
    );

    ser2par #(.CNT_W(CNT_W)) u_ser_b (
        .i_clk   (clk_read),
        .i_rst_n (reset),
        .i_en    (w_en_shift),
        .i_bit   (SerOutB),
        .i_last  (w_last_bit),
        .o_word  (w_word_b),
        .o_done  (w_done_b)
    );

    always_ff @(posedge clk_read or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        shutterA     = 1'b0;
        chain_clk_en = 1'b0;
        case (r_state)
            IDLE:   if (w_start_ok) w_next = ACQ;
            ACQ: begin
                shutterA     = 1'b1;
                chain_clk_en = 1'b1;
                if (r_cnt == ACQ_W'(1)) w_next = SETTLE;
            end
            SETTLE: if (r_cnt == '0) w_next = SHIFT;
            SHIFT: begin
                chain_clk_en = w_en_shift;
                if (w_en_shift && w_last_bit && (r_pix == '0)) w_next = DRAIN;
            end
            DRAIN:  if (w_drain_ok) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // One down-counter serves both the shutter window and the settle gap.
    always_ff @(posedge clk_read or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE:    if (w_start_ok) r_cnt <= (acq_len == '0) ? ACQ_W'(1) : acq_len;
                ACQ:     r_cnt <= (r_cnt == ACQ_W'(1)) ? ACQ_W'(SETTLE_CYC - 1) : r_cnt - 1'b1;
                SETTLE:  r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Both counters wrap on the final bit, leaving them ready for the next frame.
    always_ff @(posedge clk_read or negedge reset) begin
        if (!reset) begin
            r_bit <= '0;
            r_pix <= LAST_PIX;
        end else if (w_en_shift) begin
            if (w_last_bit) begin
                r_bit <= '0;
                r_pix <= (r_pix == '0) ? LAST_PIX : r_pix - 1'b1;
            end else begin
                r_bit <= r_bit + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_read or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else begin
            if (r_valid && out_ready) r_valid <= 1'b0;
            if (w_word_done && w_keep) begin
                r_valid <= 1'b1;
                r_addr  <= r_pix;
                r_cnt_a <= w_word_a;
                r_cnt_b <= w_word_b;
            end
        end
    end

    always_ff @(posedge clk_read or negedge reset) begin
        if (!reset) r_frame_done <= 1'b0;
        else        r_frame_done <= (r_state == DRAIN) && w_drain_ok;
    end

    assign shutterB    = shutterA;
    assign SerInA      = 1'b0;
    assign SerInB      = 1'b0;
    assign out_valid   = r_valid;
    assign out_addr    = r_addr;
    assign out_cnt_a   = r_cnt_a;
    assign out_cnt_b   = r_cnt_b;
    assign busy        = (r_state != IDLE) || r_frame_done;
    assign frame_done  = r_frame_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_column_readout_ctrl.sv
// Bench for column_readout_ctrl: daisy-chain model, scoreboard of expected words, frame checks.
`timescale 1ns/1ps
module tb_column_readout_ctrl;
  import readout_pkg::*;

  localparam int N  = N_PIX_DEF;
  localparam int W  = CNT_W_DEF;
  localparam int AW = ADDR_W_DEF;
  localparam int NW = N * W;
  localparam int EW = AW + 2 * W;
  localparam logic [W-1:0] SEED = SEED_DEF;
`ifdef ZERO_SUPPRESS_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic clk, rst_n, start, out_ready;
  logic [ACQ_W_DEF-1:0] acq_len;
  logic shutterA, shutterB, chain_clk_en, SerInA, SerInB, SerOutA, SerOutB;
  logic out_valid, busy, frame_done;
  logic [AW-1:0] out_addr;
  logic [W-1:0] out_cnt_a, out_cnt_b;
  state_t dbg_state;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  column_readout_ctrl dut (
    .clk_read(clk), .reset(rst_n), .start(start), .acq_len(acq_len),
    .shutterA(shutterA), .shutterB(shutterB), .chain_clk_en(chain_clk_en),
    .SerInA(SerInA), .SerInB(SerInB), .SerOutA(SerOutA), .SerOutB(SerOutB),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_cnt_a(out_cnt_a), .out_cnt_b(out_cnt_b), .busy(busy),
    .frame_done(frame_done), .o_dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_en_shift, n_shut, n_shut_b, n_gap, n_words, n_fd, last_acc, fd_cyc, n_exp;
  logic seen_shut, seen_shift, fd_busy, frame_arm;
  logic [NW-1:0] chain_a, chain_b, pre_a, pre_b;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_w;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // chain model: last pixel's MSB drives SerOut; shifts on each gated edge in shift mode
  assign SerOutA = chain_a[NW-1];
  assign SerOutB = chain_b[NW-1];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (frame_arm) begin
      chain_a    <= pre_a;
      chain_b    <= pre_b;
      n_en_shift <= 0;
    end else if (chain_clk_en && !shutterA) begin
      chain_a    <= {chain_a[NW-2:0], SerInA};
      chain_b    <= {chain_b[NW-2:0], SerInB};
      n_en_shift <= n_en_shift + 1;
    end
  end

  // monitor + scoreboard
  always @(negedge clk) begin
    if (frame_arm) begin
      n_shut <= 0; n_shut_b <= 0; n_gap <= 0; n_words <= 0; n_fd <= 0;
      last_acc <= 0; fd_cyc <= 0; seen_shut <= 1'b0; seen_shift <= 1'b0; fd_busy <= 1'b0;
    end else begin
      if (shutterA) begin
        n_shut    <= n_shut + 1;
        seen_shut <= 1'b1;
      end
      if (shutterB) n_shut_b <= n_shut_b + 1;
      if (seen_shut && !shutterA && !seen_shift) begin
        if (chain_clk_en) seen_shift <= 1'b1;
        else              n_gap <= n_gap + 1;
      end
      if (out_valid && out_ready) begin
        n_words  <= n_words + 1;
        last_acc <= cyc;
        if (exp_q.size() == 0) begin
          check("sb_underflow", exp_q.size(), 1);
        end else begin
          exp_w = exp_q.pop_front();
          check("word", 32'({out_addr, out_cnt_a, out_cnt_b}), 32'(exp_w));
        end
      end
      if (frame_done) begin
        n_fd    <= n_fd + 1;
        fd_cyc  <= cyc;
        fd_busy <= busy;
      end
    end
  end

  // driver tasks
  task automatic set_pattern(input int kind);
    logic [W-1:0] a, b;
    for (int i = 0; i < N; i++) begin
      case (kind)
        0: begin a = W'(i); b = W'(8'hA0 + i); end
        1: begin
          a = SEED; b = SEED;
          if (i == 3) a = 8'h3C;
          if (i == 9) b = 8'h96;
        end
        default: begin a = W'($urandom_range(0, 255)); b = W'($urandom_range(0, 255)); end
      endcase
      pre_a[i*W +: W] = a;
      pre_b[i*W +: W] = b;
    end
    n_exp = 0;
    for (int p = N - 1; p >= 0; p--) begin
      a = pre_a[p*W +: W];
      b = pre_b[p*W +: W];
      if (!(ZS && a == SEED && b == SEED)) begin
        exp_q.push_back({AW'(p), a, b});
        n_exp++;
      end
    end
  endtask

  task automatic start_frame(input int acq);
    @(posedge clk); #1;
    acq_len = ACQ_W_DEF'(acq);
    start = 1'b1;
    frame_arm = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    frame_arm = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input bit rnd);
    bit done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(posedge clk); #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      if (n_fd != 0) done = 1'b1;
    end
    check("frame_done_seen", done, 1);
    out_ready = 1'b1;
  endtask

  task automatic frame_checks(input int acq_exp, input int words_exp);
    repeat (3) @(posedge clk);
    #1;
    check("shutterA_cycles", n_shut, acq_exp);
    check("shutterB_cycles", n_shut_b, acq_exp);
    check("settle_gap", n_gap, 2);
    check("shift_edges", n_en_shift, NW);
    check("word_count", n_words, words_exp);
    check("sb_leftover", exp_q.size(), 0);
    check("frame_done_pulses", n_fd, 1);
    check("done_latency", fd_cyc, last_acc + 1);
    check("busy_at_done", fd_busy, 1);
    check("busy_idle", busy, 0);
    check("state_idle", dbg_state, IDLE);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acq_r;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1; acq_len = '0; frame_arm = 1'b0;
    pre_a = '0; pre_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_shutter", {shutterA, shutterB}, 0);
    check("rst_chain_en", chain_clk_en, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_data", 32'({out_addr, out_cnt_a, out_cnt_b}), 0);
    check("rst_state", dbg_state, IDLE);
    check("serin_zero", {SerInA, SerInB}, 0);
    rst_n = 1'b1;

    // full readout, 5-cycle window
    set_pattern(0);
    start_frame(5);
    wait_done(0);
    frame_checks(5, n_exp);

    // backpressure on the first word
    set_pattern(0);
    out_ready = 1'b0;
    start_frame(4);
    for (int i = 0; i < 400 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    check("bp_first_valid", out_valid, 1);
    repeat (20) @(posedge clk);
    #1;
    check("bp_clk_gated", chain_clk_en, 0);
    check("bp_edges_held", n_en_shift, 2 * W - 1);
    check("bp_valid_hold", out_valid, 1);
    check("bp_addr_hold", out_addr, N - 1);
    check("bp_cnt_hold", out_cnt_a, N - 1);
    out_ready = 1'b1;
    wait_done(0);
    frame_checks(4, n_exp);

    // acq_len = 0 acts as a 1-cycle window
    set_pattern(0);
    start_frame(0);
    wait_done(0);
    frame_checks(1, n_exp);

    // start while shifting is ignored
    set_pattern(2);
    start_frame(2);
    for (int i = 0; i < 400 && n_en_shift < 20; i++) begin
      @(posedge clk); #1;
    end
    check("shift_reached", n_en_shift >= 20, 1);
    acq_len = 16'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("stray_start_state", dbg_state, SHIFT);
    wait_done(0);
    frame_checks(2, n_exp);
    repeat (10) @(posedge clk);
    #1;
    check("no_second_frame", busy, 0);
    check("single_done", n_fd, 1);

    // reset in the middle of SHIFT, then a clean frame
    set_pattern(2);
    start_frame(3);
    for (int i = 0; i < 400 && n_en_shift < 40; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_shutter", {shutterA, shutterB}, 0);
    check("mid_rst_chain_en", chain_clk_en, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_state", dbg_state, IDLE);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_pattern(0);
    start_frame(6);
    wait_done(0);
    frame_checks(6, n_exp);

    // zero-suppression pattern: only pixels 3 and 9 hold hits
    set_pattern(1);
    start_frame(1);
    wait_done(0);
    frame_checks(1, n_exp);
    check("zs_words", n_words, ZS ? 2 : N);

    // random data with random backpressure
    for (int f = 0; f < 3; f++) begin
      acq_r = $urandom_range(1, 9);
      set_pattern(2);
      start_frame(acq_r);
      wait_done(1);
      frame_checks(acq_r, n_exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
